// File: rtl/bt_cmd_rx.sv
// bt_cmd_rx: 8N1 UART receiver plus key-command decoder for the Bluetooth
// player-control link. ASCII keys become a one-hot direction word and a
// pause level for the horizontal-position stage.
//
// Optional build macro: BT_HOLD_TIMEOUT_EN
//   defined   - a direction is dropped HOLD_CYCLES clocks after its last
//               direction byte unless refreshed by another direction byte.
//   undefined - a direction stays latched until 'X', another direction
//               byte, or reset.
module bt_cmd_rx #(
  parameter int CLK_HZ      = 100000000,
  parameter int BAUD        = 9600,
  parameter int HOLD_CYCLES = 20000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] dir,
  output logic       pause,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  // Clocks per bit and the counter compare points derived from it.
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int BAUD_W = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CPB - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);

  // Direction encodings as seen by the position stage.
  localparam logic [3:0] DIR_LEFT  = 4'b1000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0100;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_NONE  = 4'b0000;

  // Elaboration-time sanity checks: the half-bit wait needs CPB >= 2, and a
  // zero hold time would make the timeout meaningless.
  if (CPB < 2) begin : g_cpb_check
    $error("bt_cmd_rx: CLK_HZ/BAUD must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_hold_check
    $error("bt_cmd_rx: HOLD_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state;
  logic                rx_meta;
  logic                rxs;
  logic [BAUD_W-1:0]   baud_cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift_data;

  // Decoded view of the last received byte.
  logic [3:0]          key_dir;
  logic                key_is_dir;
  logic                key_is_stop;
  logic                key_is_pause;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: start-bit validation at mid-bit, 8 data bits LSB first,
  // stop-bit check with one-cycle byte_valid / frame_err pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_data <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state    <= S_START;
            baud_cnt <= '0;
          end
        end
        S_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (!rxs) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt            <= '0;
            shift_data[bit_idx] <= rxs;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
            if (rxs) begin
              rx_byte    <= shift_data;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Key decode of the held byte; only acted on while byte_valid is high.
  always_comb begin
    key_dir      = DIR_NONE;
    key_is_dir   = 1'b0;
    key_is_stop  = 1'b0;
    key_is_pause = 1'b0;
    case (rx_byte)
      8'h41, 8'h61: begin key_dir = DIR_LEFT;  key_is_dir = 1'b1; end
      8'h44, 8'h64: begin key_dir = DIR_RIGHT; key_is_dir = 1'b1; end
      8'h57, 8'h77: begin key_dir = DIR_UP;    key_is_dir = 1'b1; end
      8'h53, 8'h73: begin key_dir = DIR_DOWN;  key_is_dir = 1'b1; end
      8'h58, 8'h78: key_is_stop  = 1'b1;
      8'h50, 8'h70: key_is_pause = 1'b1;
      default: ;
    endcase
  end

`ifdef BT_HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  logic [HOLD_W-1:0] hold_cnt;

  // Command register with hold timeout: a direction byte reloads the
  // counter and takes priority over an expiry landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir      <= DIR_NONE;
      pause    <= 1'b0;
      hold_cnt <= '0;
    end else if (byte_valid && key_is_dir) begin
      dir      <= key_dir;
      hold_cnt <= HOLD_LOAD;
    end else begin
      if (byte_valid && key_is_stop) begin
        dir <= DIR_NONE;
      end
      if (byte_valid && key_is_pause) begin
        pause <= ~pause;
      end
      if (dir != DIR_NONE) begin
        if (hold_cnt <= HOLD_ONE) begin
          dir      <= DIR_NONE;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end
      end
    end
  end
`else
  // Command register: direction stays latched until changed or stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir   <= DIR_NONE;
      pause <= 1'b0;
    end else if (byte_valid) begin
      if (key_is_dir) begin
        dir <= key_dir;
      end else if (key_is_stop) begin
        dir <= DIR_NONE;
      end
      if (key_is_pause) begin
        pause <= ~pause;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bt_cmd_rx.sv
// Directed testbench for bt_cmd_rx with CPB=10 and HOLD_CYCLES=500.
module tb_bt_cmd_rx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int HOLD   = 500;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [3:0] dir;
  logic       pause;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int v_count  = 0;
  int e_count  = 0;
  int v_last   = 0;
  int v_prev   = 0;
  int v0;
  int e0;
  int n;

  bt_cmd_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .dir(dir),
    .pause(pause),
    .byte_valid(byte_valid),
    .rx_byte(rx_byte),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (byte_valid) begin
      v_count = v_count + 1;
      v_prev  = v_last;
      v_last  = cycle;
    end
    if (frame_err) e_count = e_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One bit period, starting #1 after a rising edge.
  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dir", {28'd0, dir}, 32'h0);
    check("reset_pause", {31'd0, pause}, 32'h0);
    check("reset_rx_byte", {24'd0, rx_byte}, 32'h0);
    check("reset_byte_valid", {31'd0, byte_valid}, 32'h0);
    check("reset_frame_err", {31'd0, frame_err}, 32'h0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Clean 'A'.
    v0 = v_count; e0 = e_count;
    send_frame(8'h41, 1'b1);
    check("A_valid_pulses", v_count - v0, 1);
    check("A_rx_byte", {24'd0, rx_byte}, 32'h41);
    check("A_dir", {28'd0, dir}, 32'h8);
    check("A_no_frame_err", e_count - e0, 0);

    // 'd' then 'x' back-to-back.
    v0 = v_count;
    send_frame(8'h64, 1'b1);
    check("d_dir", {28'd0, dir}, 32'h1);
    send_frame(8'h78, 1'b1);
    check("x_dir", {28'd0, dir}, 32'h0);
    check("dx_valid_pulses", v_count - v0, 2);
    check("dx_pulse_spacing", v_last - v_prev, 10 * CPB);

    // 'P', 'W', 'P'.
    send_frame(8'h50, 1'b1);
    check("P1_pause", {31'd0, pause}, 32'h1);
    send_frame(8'h57, 1'b1);
    check("W_pause", {31'd0, pause}, 32'h1);
    check("W_dir", {28'd0, dir}, 32'h4);
    send_frame(8'h50, 1'b1);
    check("P2_pause", {31'd0, pause}, 32'h0);
    check("P2_dir", {28'd0, dir}, 32'h4);

    // Framing error on 'A', after clearing dir with 'X'.
    send_frame(8'h58, 1'b1);
    v0 = v_count; e0 = e_count;
    send_frame(8'h41, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("ferr_pulses", e_count - e0, 1);
    check("ferr_no_valid", v_count - v0, 0);
    check("ferr_dir", {28'd0, dir}, 32'h0);
    send_frame(8'h41, 1'b1);
    check("A_after_ferr_dir", {28'd0, dir}, 32'h8);

    // Three-cycle low glitch.
    v0 = v_count; e0 = e_count;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_no_valid", v_count - v0, 0);
    check("glitch_no_ferr", e_count - e0, 0);

    // Set pause, then reset in the middle of an 'S' frame.
    send_frame(8'h70, 1'b1);
    check("p_pause", {31'd0, pause}, 32'h1);
    v0 = v_count; e0 = e_count;
    fork
      send_frame(8'h53, 1'b1);
      begin
        repeat (45) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_dir", {28'd0, dir}, 32'h0);
        check("midrst_pause", {31'd0, pause}, 32'h0);
        repeat (47) @(posedge clk);
        #2 rst = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_valid", v_count - v0, 0);
    check("midrst_no_ferr", e_count - e0, 0);
    check("midrst_rx_byte", {24'd0, rx_byte}, 32'h0);
    check("midrst_dir_after", {28'd0, dir}, 32'h0);
    send_frame(8'h53, 1'b1);
    check("S_rx_byte", {24'd0, rx_byte}, 32'h53);
    check("S_dir", {28'd0, dir}, 32'h2);

    // Direction hold behaviour. dir is set on the edge one cycle before
    // send_frame returns, so a 500-cycle hold shows 499 further samples.
    send_frame(8'h44, 1'b1);
    check("D_dir", {28'd0, dir}, 32'h1);
`ifdef BT_HOLD_TIMEOUT_EN
    n = 0;
    while (dir != 4'b0000 && n < 2000) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check("hold_expiry_cycles", n, HOLD - 1);
    // Second 'D' decoded 400 cycles after the first one.
    send_frame(8'h44, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    send_frame(8'h44, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    check("hold_refresh_dir", {28'd0, dir}, 32'h1);
    n = 0;
    while (dir != 4'b0000 && n < 2000) begin
      @(posedge clk);
      #1;
      n = n + 1;
    end
    check("hold_refresh_cycles", n, HOLD - 101);
`else
    repeat (2000) @(posedge clk);
    #1;
    check("latched_dir_2000", {28'd0, dir}, 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
- UART receiver and command decoder for the Bluetooth serial module (8N1) on the player-control path.
- Turns ASCII key bytes from the phone into a one-hot direction word and a pause flag.
- Sits directly upstream of the horizontal-position stage: `dir` and `pause` drive that stage's `dir` and `ena` inputs.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- HOLD_CYCLES, 20000000, clock cycles a direction is held after its last command byte (200 ms at 100 MHz).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous active-high reset.
- rx  input  1  serial data from the Bluetooth module; idles high; asynchronous to clk.
- dir  output  4  one-hot direction: 4'b1000 left, 4'b0001 right, 4'b0100 up, 4'b0010 down, 4'b0000 none.
- pause  output  1  level; 1 = movement frozen (drives `ena` of the position stage).
- byte_valid  output  1  one-cycle pulse for every correctly framed byte received.
- rx_byte  output  8  last correctly framed byte; stable until the next byte_valid.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.

Behaviour:
- Derived constant: CPB = CLK_HZ/BAUD, integer divide. Bit counter and baud counter widths are sized from CPB and 8.
- Reset (async, rst=1): dir=0, pause=0, byte_valid=0, rx_byte=0, frame_err=0, FSM=IDLE, all counters 0, synchroniser flops=1.
- Synchronisation: rx passes through a 2-flop synchroniser. Only the synchronised signal rxs is used.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rxs=0, go to START and clear the baud counter.
  - START: wait CPB/2 cycles, then sample. If rxs=0, go to DATA with bit index 0. If rxs=1 (glitch), return to IDLE with no pulse.
  - DATA: every CPB cycles, sample rxs into bit[index], LSB first. After index 7 is sampled, go to STOP.
  - STOP: after CPB cycles, sample.
    - rxs=1: rx_byte<=shift register and byte_valid pulses in the same cycle.
    - rxs=0: frame_err pulses and the byte is discarded.
    - Both cases return to IDLE.
- Receive latency: byte_valid asserts about 9.5*CPB + 3 cycles after the start-bit falling edge on rx.
- Back-to-back bytes: IDLE accepts a new start bit on the cycle after STOP completes. No gap beyond the stop bit is required.
- Decoder (acts in the cycle after byte_valid; dir/pause update 1 cycle after the pulse):
  - 'A'/'a' (8'h41/8'h61): dir<=4'b1000.
  - 'D'/'d' (8'h44/8'h64): dir<=4'b0001.
  - 'W'/'w' (8'h57/8'h77): dir<=4'b0100.
  - 'S'/'s' (8'h53/8'h73): dir<=4'b0010.
  - 'X'/'x': dir<=0.
  - 'P'/'p': pause<=~pause; dir unchanged.
  - Any other byte: no effect on dir or pause; byte_valid still pulses.
- Framing errors never change dir or pause.
- dir is always one-hot or zero, never multi-hot.
- Reset mid-frame: FSM returns to IDLE immediately. A partially received byte is lost and no pulse is produced.

Optional Feature:
- Macro: BT_HOLD_TIMEOUT_EN.
- Defined:
  - A hold counter reloads to HOLD_CYCLES on every direction byte (A/D/W/S).
  - It decrements each cycle while dir!=0; when it reaches 0, dir<=0.
  - 'X', pause toggles, and other bytes do not reload it.
  - A reload in the same cycle as expiry wins, so dir takes the new value.
- Not defined:
  - No hold counter is built.
  - dir stays latched until 'X', another direction byte, or reset.

Test Plan (bench uses CLK_HZ=1000000, BAUD=100000, so CPB=10; HOLD_CYCLES=500):
- Send 8'h41 as a clean 8N1 frame -> byte_valid pulses once, rx_byte=8'h41, dir=4'b1000 one cycle later, frame_err stays 0.
- Send 'd' then 'x' back-to-back with no idle gap -> dir goes 4'b0001, then 4'b0000; two byte_valid pulses, 100 cycles apart.
- Send 'P', 'W', 'P' -> pause sequence 1, 1, 0; dir=4'b0100 after 'W' and remains 4'b0100 after the second 'P'.
- Send 'A' with the stop bit driven low -> frame_err pulses once, no byte_valid pulse, dir stays 0; a following clean 'A' sets dir=4'b1000.
- Pull rx low for 3 cycles only, then high -> no byte_valid and no frame_err; FSM back in IDLE. Separately, assert rst mid-DATA of an 'S' frame -> all outputs 0 and no pulses for that frame.
- BT_HOLD_TIMEOUT_EN defined:
  - Send 'D' -> dir=4'b0001 for 500 cycles after the decode cycle, then 0.
  - Resend 'D' at cycle 400 -> dir holds until 500 cycles after the second decode.
  - Without the macro: dir=4'b0001 persists after 2000 cycles.
